// File: rtl/sort_stream.sv
// sort_stream: batch sorter that loads up to DEPTH keys, runs DEPTH odd-even
// transposition passes (one per cycle), then streams the sorted keys out.
module sort_stream #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_desc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, rem_q, rem_d;
  logic [PW-1:0] pass_q, pass_d;
  logic desc_q, desc_d;
  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [DATA_W-1:0] slot_d [DEPTH];
  logic accept, xfer, desc_eff, fill;
  logic [DATA_W-1:0] pad;
  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == DRAIN;
  assign busy      = state_q != LOAD;
  assign out_data  = out_valid ? slot_q[0] : '0;
  assign out_last  = out_valid && rem_q == CW'(1);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign desc_eff  = cnt_q == '0 ? in_desc : desc_q;
  // Pad sorts behind every real key, and ties never swap, so pad stays at the tail
  assign pad       = desc_eff ? '0 : '1;
  assign fill      = accept && (in_last || cnt_q == CW'(DEPTH - 1));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    pass_d  = pass_q;
    desc_d  = desc_q;
    slot_d  = slot_q;
    case (state_q)
      LOAD: if (accept) begin
        cnt_d  = cnt_q + 1'b1;
        desc_d = desc_eff;
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == cnt_q) slot_d[i] = in_data;
          else if (fill && CW'(i) > cnt_q) slot_d[i] = pad;
        if (fill) begin
          state_d = SORT;
          pass_d  = '0;
        end
      end
      SORT: begin
        for (int i = 0; i < DEPTH - 1; i++)
          if (i % 2 == int'(pass_q[0]) &&
              (desc_q ? slot_q[i] < slot_q[i+1] : slot_q[i] > slot_q[i+1])) begin
            slot_d[i]   = slot_q[i+1];
            slot_d[i+1] = slot_q[i];
          end
        pass_d = pass_q + 1'b1;
        if (pass_q == PW'(DEPTH - 1)) begin
          state_d = DRAIN;
          rem_d   = cnt_q;
        end
      end
      DRAIN: if (xfer) begin
        for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
        rem_d = rem_q - 1'b1;
        if (rem_q == CW'(1)) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      rem_q   <= '0;
      pass_q  <= '0;
      desc_q  <= 1'b0;
      slot_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
      desc_q  <= desc_d;
      slot_q  <= slot_d;
    end
  end
endmodule

// File: tb/tb_sort_stream.sv
// tb_sort_stream: directed scenarios for sort_stream with hand-computed results.
module tb_sort_stream;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, in_desc = 0, out_ready = 0;
  logic [11:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [11:0] out_data;
  int total = 0, bad = 0, cyc = 0;
  logic [11:0] vec [8];
  logic [11:0] exp_d [8];
  logic [11:0] got_d [16];
  logic got_l [16];
  int got, first_v, t_acc, last_cyc, hold_bad, rdy_bad;
  bit tmo;

  sort_stream #(.DATA_W(12), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_desc(in_desc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send(input int n, input logic desc);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      in_valid = 1; in_data = vec[i]; in_last = (i == n - 1); in_desc = desc;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      if (w >= 100) tmo = 1;
      t_acc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic collect(input bit toggle);
    bit ph = 0, have_prev = 0, done = 0, prev_l;
    logic [11:0] prev_d;
    got = 0; first_v = -1; hold_bad = 0; rdy_bad = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      out_ready = toggle ? ph : 1'b1;
      ph = !ph;
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (in_ready) rdy_bad++;
        if (have_prev && (out_data !== prev_d || out_last !== prev_l)) hold_bad++;
        have_prev = !out_ready; prev_d = out_data; prev_l = out_last;
        if (out_ready && got < 16) begin got_d[got] = out_data; got_l[got] = out_last; got++; end
      end
      done = out_valid && out_ready && out_last;
      if (done) last_cyc = cyc;
      @(posedge clk); #1;
    end
    if (!done) tmo = 1;
    out_ready = 0;
  endtask

  task automatic check_out(input string nm, input int n);
    total++;
    if (tmo || got !== n) begin bad++; $display("FAIL %s count got=%0d want=%0d tmo=%0d", nm, got, n, tmo); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == n - 1)) begin
        bad++;
        $display("FAIL %s out[%0d] got=%h/%0b want=%h/%0b", nm, i, got_d[i], got_l[i], exp_d[i], i == n - 1);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid, out_last, busy} !== 4'b1000 || out_data !== 12'h0) begin
      bad++; $display("FAIL reset rdy/val/last/busy=%b data=%h want 1000/000", {in_ready, out_valid, out_last, busy}, out_data);
    end
    rst = 0; @(posedge clk); #1;
  endtask

  task automatic test_full_asc;
    vec = '{12'h7, 12'h3, 12'hF00, 12'h0, 12'h3, 12'h9, 12'h1, 12'h2};
    exp_d = '{12'h0, 12'h1, 12'h2, 12'h3, 12'h3, 12'h7, 12'h9, 12'hF00};
    tmo = 0; send(8, 0);
    total++;
    if (busy !== 1 || in_ready !== 0) begin bad++; $display("FAIL full_asc sort busy=%b rdy=%b want 1/0", busy, in_ready); end
    collect(0);
    check_out("full_asc", 8);
    total++;
    if (first_v - t_acc !== 9) begin bad++; $display("FAIL full_asc latency got=%0d want=9", first_v - t_acc); end
    total++;
    if (in_ready !== 1 || out_valid !== 0) begin bad++; $display("FAIL full_asc after rdy=%b val=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_full_desc;
    exp_d = '{12'hF00, 12'h9, 12'h7, 12'h3, 12'h3, 12'h2, 12'h1, 12'h0};
    tmo = 0; send(8, 1); collect(0);
    check_out("full_desc", 8);
  endtask

  task automatic test_partial;
    vec[0] = 12'hFFF; vec[1] = 12'h5; vec[2] = 12'hFFF;
    exp_d[0] = 12'h5; exp_d[1] = 12'hFFF; exp_d[2] = 12'hFFF;
    tmo = 0; send(3, 0); collect(0);
    check_out("partial", 3);
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin bad++; $display("FAIL partial pad val=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_pressure;
    vec = '{12'h7, 12'h3, 12'hF00, 12'h0, 12'h3, 12'h9, 12'h1, 12'h2};
    exp_d = '{12'h0, 12'h1, 12'h2, 12'h3, 12'h3, 12'h7, 12'h9, 12'hF00};
    tmo = 0; send(8, 0); collect(1);
    check_out("bp", 8);
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL bp hold changes=%0d want 0", hold_bad); end
    total++;
    if (rdy_bad !== 0) begin bad++; $display("FAIL bp in_ready_high=%0d want 0", rdy_bad); end
    total++;
    if (in_ready !== 1) begin bad++; $display("FAIL bp final rdy=%b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_sort;
    tmo = 0; send(8, 0);
    repeat (3) @(posedge clk); #1;
    rst = 1; #1;
    total++;
    if (out_valid !== 0 || in_ready !== 1 || busy !== 0) begin
      bad++; $display("FAIL rst_mid val=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    #2 rst = 0;
    @(posedge clk); #1;
    vec[0] = 12'h123; exp_d[0] = 12'h123;
    send(1, 0); collect(0);
    check_out("rst_mid", 1);
  endtask

  task automatic test_back_to_back;
    vec[0] = 12'h5; vec[1] = 12'h1;
    exp_d[0] = 12'h1; exp_d[1] = 12'h5;
    tmo = 0; send(2, 0);
    in_valid = 1; in_data = 12'hABC; in_last = 1; in_desc = 0;
    collect(0);
    check_out("b2b_a", 2);
    total++;
    if (in_ready !== 1 || cyc !== last_cyc + 1) begin
      bad++; $display("FAIL b2b accept rdy=%b dcyc=%0d want 1/1", in_ready, cyc - last_cyc);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    total++;
    if (busy !== 1) begin bad++; $display("FAIL b2b second busy=%b want 1", busy); end
    exp_d[0] = 12'hABC;
    collect(0);
    check_out("b2b_b", 1);
  endtask

  initial begin
    test_reset;
    test_full_asc;
    test_full_desc;
    test_partial;
    test_back_pressure;
    test_reset_mid_sort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
